dmem_arbiter: RTL and testbench

- Sequences and shares the single-port data RAM between two requesters: the CPU load/store path (port A, fed from the memory/IO decode stage) and the program/debug loader (port B).
- Registers each request, drives the RAM enable, address and write data, and waits a fixed read latency.
- Returns read data with a one-cycle acknowledge pulse to the winning port.

---
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data RAM (CPU port A, loader port B).
// Optional macro DMEM_ARB_ROUND_ROBIN_EN replaces fixed B-over-A priority with round-robin.
module dmem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(RD_LAT - 1);

  state_t     state;
  state_t     state_d;
  logic [3:0] cnt;
  logic       win_b;
  logic       start;
  logic       grant_b;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_b;

  // Ties go to the port that did not win last time; a lone request always wins.
  always_comb begin
    start   = a_req | b_req;
    grant_b = b_req & (~a_req | ~last_b);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_b <= 1'b1;
    end else if (state == IDLE && start) begin
      last_b <= grant_b;
    end
  end
`else
  always_comb begin
    start   = a_req | b_req;
    grant_b = b_req;
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    mem_en  = 1'b0;
    a_ack   = 1'b0;
    b_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_d = ISSUE;
      end
      ISSUE: begin
        mem_en  = 1'b1;
        state_d = mem_we ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) state_d = DONE;
      end
      DONE: begin
        a_ack   = ~win_b;
        b_ack   = win_b;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Request latch, latency counter and per-port read-data capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      win_b     <= 1'b0;
      cnt       <= 4'd0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            win_b     <= grant_b;
            mem_we    <= grant_b ? b_we    : a_we;
            mem_addr  <= grant_b ? b_addr  : a_addr;
            mem_wdata <= grant_b ? b_wdata : a_wdata;
          end
        end
        ISSUE: begin
          if (!mem_we) cnt <= CNT_LOAD;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (win_b) b_rdata <= mem_rdata;
            else       a_rdata <= mem_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: RD_LAT=1 instance with a RAM model, RD_LAT=4 instance
// with bench-driven mem_rdata.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RD_LAT=1 instance
  logic        a_req, a_we, b_req, b_we;
  logic [13:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_ack, b_ack, mem_en, mem_we, busy;
  logic [31:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic [13:0] mem_addr;

  // RD_LAT=4 instance
  logic        a4_req, a4_we, b4_req, b4_we;
  logic [13:0] a4_addr, b4_addr;
  logic [31:0] a4_wdata, b4_wdata;
  logic        a4_ack, b4_ack, mem_en4, mem_we4, busy4;
  logic [31:0] a4_rdata, b4_rdata, mem_wdata4, mem_rdata4;
  logic [13:0] mem_addr4;

  dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .RD_LAT(1)) dut (
    .clock(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .RD_LAT(4)) dut4 (
    .clock(clk), .reset_n(reset_n),
    .a_req(a4_req), .a_we(a4_we), .a_addr(a4_addr), .a_wdata(a4_wdata), .a_ack(a4_ack), .a_rdata(a4_rdata),
    .b_req(b4_req), .b_we(b4_we), .b_addr(b4_addr), .b_wdata(b4_wdata), .b_ack(b4_ack), .b_rdata(b4_rdata),
    .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_rdata(mem_rdata4), .busy(busy4)
  );

  // Synchronous single-port RAM, one cycle read latency; word 0x0010 preset.
  logic [31:0] ram [0:16383];
  always @(posedge clk) begin
    if (cyc == 0) ram[14'h0010] <= 32'hDEADBEEF;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  typedef struct {
    bit          is_b;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;

  function automatic exp_t mk(input bit b, input logic [31:0] d, input int c);
    exp_t r;
    r.is_b  = b;
    r.rdata = d;
    r.cyc   = c;
    return r;
  endfunction

  // Monitors: every ack is matched against the oldest expected completion.
  always @(negedge clk) begin
    if (a_ack || b_ack) begin
      if (q1.size() == 0) chk("unexpected_ack", {a_ack, b_ack}, 2'b00);
      else begin
        e1 = q1.pop_front();
        chk("ack_port", {a_ack, b_ack}, e1.is_b ? 2'b01 : 2'b10);
        chk("ack_rdata", e1.is_b ? b_rdata : a_rdata, e1.rdata);
        chk("ack_cycle", cyc, e1.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (a4_ack || b4_ack) begin
      if (q4.size() == 0) chk("unexpected_ack4", {a4_ack, b4_ack}, 2'b00);
      else begin
        e4 = q4.pop_front();
        chk("ack4_port", {a4_ack, b4_ack}, e4.is_b ? 2'b01 : 2'b10);
        chk("ack4_rdata", e4.is_b ? b4_rdata : a4_rdata, e4.rdata);
        chk("ack4_cycle", cyc, e4.cyc);
      end
    end
  end

  task automatic wait_drop(input bit is_b);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (is_b ? b_ack : a_ack) begin
        seen = 1'b1;
        if (is_b) b_req = 1'b0;
        else      a_req = 1'b0;
      end
    end
    chk("ack_arrived", seen, 1'b1);
  endtask

  task automatic single_req(input bit is_b, input bit we, input logic [13:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp_rd);
    @(negedge clk);
    if (is_b) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    else      begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    q1.push_back(mk(is_b, exp_rd, cyc + (we ? 2 : 3)));
    wait_drop(is_b);
  endtask

  task automatic tie_round();
    bit ga = 1'b0;
    bit gb = 1'b0;
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0010;
    b_req = 1'b1; b_we = 1'b0; b_addr = 14'h3FFF;
    if (RR) begin
      q1.push_back(mk(1'b0, 32'hDEADBEEF, cyc + 3));
      q1.push_back(mk(1'b1, 32'h12345678, cyc + 7));
    end else begin
      q1.push_back(mk(1'b1, 32'h12345678, cyc + 3));
      q1.push_back(mk(1'b0, 32'hDEADBEEF, cyc + 7));
    end
    for (int i = 0; i < 30 && !(ga && gb); i++) begin
      @(negedge clk);
      if (a_ack) begin ga = 1'b1; a_req = 1'b0; end
      if (b_ack) begin gb = 1'b1; b_req = 1'b0; end
    end
    chk("tie_both_served", {ga, gb}, 2'b11);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    a4_req = 0; a4_we = 0; a4_addr = '0; a4_wdata = '0;
    b4_req = 0; b4_we = 0; b4_addr = '0; b4_wdata = '0;
    mem_rdata4 = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    chk("reset_ctrl", {a_ack, b_ack, mem_en, mem_we, busy, a4_ack, b4_ack, mem_en4, mem_we4, busy4}, '0);
    chk("reset_addr_data", {mem_addr, mem_wdata}, '0);
    chk("reset_rdata", {a_rdata, b_rdata}, '0);
    chk("reset4_data", {mem_addr4, mem_wdata4}, '0);
    chk("reset4_rdata", {a4_rdata, b4_rdata}, '0);
    reset_n = 1'b1;
    @(negedge clk);

    // single read on A with ISSUE/WAIT bus checks
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0010; a_wdata = 32'h0BAD0BAD;
    q1.push_back(mk(1'b0, 32'hDEADBEEF, cyc + 3));
    @(negedge clk);
    chk("rd_issue_ctrl", {mem_en, mem_we, busy}, 3'b101);
    chk("rd_issue_addr", mem_addr, 14'h0010);
    @(negedge clk);
    chk("rd_wait_ctrl", {mem_en, busy}, 2'b01);
    wait_drop(1'b0);

    // B write to top address, then read back
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_addr = 14'h3FFF; b_wdata = 32'h12345678;
    q1.push_back(mk(1'b1, 32'h0, cyc + 2));
    @(negedge clk);
    chk("wr_issue_ctrl", {mem_en, mem_we}, 2'b11);
    chk("wr_issue_addr_data", {mem_addr, mem_wdata}, {14'h3FFF, 32'h12345678});
    b_wdata = 32'hFFFF0000;
    wait_drop(1'b1);
    single_req(1'b1, 1'b0, 14'h3FFF, 32'h0, 32'h12345678);

    // A write must leave a_rdata alone; read it back afterwards
    single_req(1'b0, 1'b1, 14'h0020, 32'hA5A55A5A, 32'hDEADBEEF);
    single_req(1'b0, 1'b0, 14'h0020, 32'h0, 32'hA5A55A5A);

    // simultaneous requests, two rounds
    do_reset();
    tie_round();
    tie_round();

    // RD_LAT=4: only the last WAIT cycle's mem_rdata may be captured
    @(negedge clk);
    a4_req = 1'b1; a4_we = 1'b0; a4_addr = 14'h0ABC;
    mem_rdata4 = 32'hFFFFFFFF;
    q4.push_back(mk(1'b0, 32'hCAFEF00D, cyc + 6));
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      case (i)
        1: chk("lat4_issue", {mem_en4, mem_addr4}, {1'b1, 14'h0ABC});
        2: begin chk("lat4_wait_en", {mem_en4, busy4}, 2'b01); mem_rdata4 = 32'h11111111; end
        3: mem_rdata4 = 32'h22222222;
        4: mem_rdata4 = 32'h33333333;
        5: begin chk("lat4_no_early_ack", a4_ack, 1'b0); mem_rdata4 = 32'hCAFEF00D; end
        default: begin chk("lat4_ack", a4_ack, 1'b1); a4_req = 1'b0; mem_rdata4 = 32'h55555555; end
      endcase
    end

    // reset during WAIT of a read, then a fresh read
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0010; a_wdata = 32'h0BAD0BAD;
    repeat (2) @(negedge clk);
    chk("midrst_pre_wait", {busy, mem_en}, 2'b10);
    reset_n = 1'b0;
    #1;
    chk("midrst_ctrl", {a_ack, b_ack, mem_en, mem_we, busy}, '0);
    chk("midrst_addr_data", {mem_addr, mem_wdata}, '0);
    chk("midrst_rdata", {a_rdata, b_rdata}, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    q1.push_back(mk(1'b0, 32'hDEADBEEF, cyc + 3));
    wait_drop(1'b0);

    repeat (5) @(negedge clk);
    chk("q1_drained", q1.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
